// File: rtl/vc_pkg.sv
// Shared definitions for the VC read arbiter and the VC FIFO bank:
// FSM encodings, channel count/index width and the default word width.
package vc_pkg;

  localparam int N_CH   = 4;
  localparam int CH_W   = 2;
  localparam int DEF_BW = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_PAUSE  = 2'd2
  } state_t;

endpackage

// File: rtl/vc_rd_arbiter_if.sv
// Bus between the VC FIFO bank / downstream stage and the read arbiter.
//
// Handshake: the FIFO side presents fifo_empty and first-word-fall-through
// data per channel; a fifo_rd[i] pulse in cycle N pops channel i at the end
// of cycle N, and the popped word appears on data_out with valid_out=1 in
// cycle N+1 (one cycle per word, no ready: downstream throttles only through
// pause, which stops reads in the same cycle it rises).
interface vc_rd_arbiter_if #(
  parameter int BW = vc_pkg::DEF_BW
);
  import vc_pkg::*;

  logic [N_CH-1:0]    fifo_empty;
  logic [N_CH*BW-1:0] fifo_data_in;
  logic               pause;
  logic [N_CH-1:0]    fifo_rd;
  logic [BW-1:0]      data_out;
  logic               valid_out;
  logic [CH_W-1:0]    ch_out;

  // Arbiter side
  modport master (
    input  fifo_empty, fifo_data_in, pause,
    output fifo_rd, data_out, valid_out, ch_out
  );

  // FIFO bank / downstream side
  modport slave (
    output fifo_empty, fifo_data_in, pause,
    input  fifo_rd, data_out, valid_out, ch_out
  );

endinterface

// File: rtl/vc_rd_arbiter_rr_next4.sv
// Rotating first-one finder: returns the first requesting channel after
// `last` (last+1, last+2, last+3, then last itself), plus an any-request flag.
module rr_next4
  import vc_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] last,
  output logic [CH_W-1:0] idx,
  output logic            any
);

  logic [CH_W-1:0] cand;

  // Scan farthest-first so the nearest requester after `last` wins
  always_comb begin
    idx  = last;
    any  = 1'b0;
    cand = last;
    for (int k = N_CH; k >= 1; k--) begin
      cand = last + CH_W'(k);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_rd_arbiter.sv
// Read-side arbiter for four VC FIFOs: round-robin grant with a per-grant
// burst limit, downstream pause back-pressure, tagged registered output.
// Optional macro VC_RD_STRICT_PRIO_EN: channel 0 gets strict priority
// (preempts other grants, ignores the burst limit, fixed 0>1>2>3 search).
module vc_rd_arbiter
  import vc_pkg::*;
#(
  parameter int BW        = DEF_BW,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  vc_rd_arbiter_if.master  bus,
  output logic             idle,
  output state_t           state
);

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  logic [CH_W-1:0] grant;
  logic [3:0]      burst_cnt;
  logic [N_CH-1:0] req;
  logic [CH_W-1:0] scan_base;
  logic [CH_W-1:0] next_ch;
  logic            any_req;
  logic            preempt;
  logic            burst_ok;
  logic            can_read;
  logic [BW-1:0]   words [N_CH];

  assign req = ~bus.fifo_empty;

  for (genvar i = 0; i < N_CH; i++) begin : g_words
    assign words[i] = bus.fifo_data_in[i*BW +: BW];
  end

`ifdef VC_RD_STRICT_PRIO_EN
  // Starting the scan after the last channel yields fixed priority 0>1>2>3
  assign scan_base = CH_W'(N_CH-1);
  assign preempt   = (grant != '0) && req[0];
  assign burst_ok  = (burst_cnt < MAX_B) || (grant == '0);
`else
  assign scan_base = grant;
  assign preempt   = 1'b0;
  assign burst_ok  = burst_cnt < MAX_B;
`endif

  rr_next4 u_next (
    .req  (req),
    .last (scan_base),
    .idx  (next_ch),
    .any  (any_req)
  );

  // A read happens only in ACTIVE, unpaused, on a non-empty granted channel
  assign can_read    = (state == ST_ACTIVE) && !bus.pause && req[grant] &&
                       burst_ok && !preempt;
  assign bus.fifo_rd = can_read ? (N_CH'(1) << grant) : '0;
  assign idle        = (state == ST_IDLE);

  // FSM, grant/burst bookkeeping and registered output word
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state         <= ST_IDLE;
      grant         <= CH_W'(N_CH-1);
      burst_cnt     <= '0;
      bus.data_out  <= '0;
      bus.valid_out <= 1'b0;
      bus.ch_out    <= '0;
    end else begin
      bus.valid_out <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!bus.pause && any_req) begin
            grant     <= next_ch;
            burst_cnt <= '0;
            state     <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (bus.pause) begin
            state <= ST_PAUSE;
          end else if (can_read) begin
            bus.data_out  <= words[grant];
            bus.ch_out    <= grant;
            bus.valid_out <= 1'b1;
            burst_cnt     <= (burst_cnt == 4'hF) ? burst_cnt : burst_cnt + 4'd1;
          end else if (any_req) begin
            grant     <= next_ch;
            burst_cnt <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_PAUSE: begin
          if (!bus.pause) state <= ST_ACTIVE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vc_rd_arbiter.sv
// Directed bench for vc_rd_arbiter with a behavioural FWFT FIFO bank.
// Output words are encoded {channel, index} so order and tagging are visible.
// Build with +define+VC_RD_STRICT_PRIO_EN to exercise the priority variant.
module tb_vc_rd_arbiter;
  import vc_pkg::*;

  localparam int BW = 6;
  localparam int MB = 4;

  logic   clk = 1'b0;
  logic   reset_L;
  logic   idle;
  state_t state;

  int errors = 0;
  int checks = 0;

  logic [BW-1:0] fq [N_CH][$];
  logic [8:0]    exp_q[$];
  logic [N_CH-1:0] rd_s;

  vc_rd_arbiter_if #(.BW(BW)) bus ();

  vc_rd_arbiter #(.BW(BW), .MAX_BURST(MB)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus),
    .idle    (idle),
    .state   (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- FIFO bank model ----------------
  function automatic logic [BW-1:0] mkw(int c, int j);
    return {2'(c), 4'(j)};
  endfunction

  task automatic refresh();
    for (int i = 0; i < N_CH; i++) begin
      bus.fifo_empty[i] = (fq[i].size() == 0);
      bus.fifo_data_in[i*BW +: BW] = (fq[i].size() != 0) ? fq[i][0] : '0;
    end
  endtask

  // Pop on the edge that consumed the strobe; also guard one-hot / no empty read
  always @(posedge clk) begin
    rd_s = bus.fifo_rd;
    if (reset_L === 1'b1) begin
      checks++;
      if (!$onehot0(rd_s) || ((rd_s & bus.fifo_empty) != '0)) begin
        errors++;
        $display("FAIL rd_guard: fifo_rd=%b fifo_empty=%b required one-hot on non-empty", rd_s, bus.fifo_empty);
      end
    end
    #1;
    for (int i = 0; i < N_CH; i++)
      if (rd_s[i] && fq[i].size() != 0) void'(fq[i].pop_front());
    refresh();
  end

  // ---------------- driver tasks ----------------
  task automatic load(int c, int n);
    for (int j = 0; j < n; j++) fq[c].push_back(mkw(c, j));
    refresh();
  endtask

  task automatic push_gap();
    exp_q.push_back(9'h000);
  endtask

  task automatic push_group(int c, int start, int n);
    for (int j = 0; j < n; j++) exp_q.push_back({1'b1, 2'(c), mkw(c, start + j)});
  endtask

  task automatic do_reset();
    reset_L   = 1'b0;
    bus.pause = 1'b0;
    for (int i = 0; i < N_CH; i++) fq[i].delete();
    refresh();
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_L = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_L   = 1'b0;
    bus.pause = 1'b0;
    for (int c = 0; c < N_CH; c++) load(c, 4);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.fifo_rd !== 4'b0000 || bus.valid_out !== 1'b0 || idle !== 1'b1 || state !== ST_IDLE) begin
        errors++;
        $display("FAIL reset_hold: rd=%b valid=%b idle=%b state=%0d want rd=0000 valid=0 idle=1 state=0",
                 bus.fifo_rd, bus.valid_out, idle, state);
      end
      checks++;
      if (bus.data_out !== '0 || bus.ch_out !== '0) begin
        errors++;
        $display("FAIL reset_out: data=%h ch=%0d want 0/0", bus.data_out, bus.ch_out);
      end
    end
    reset_L = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.fifo_rd !== 4'b0001 || state !== ST_ACTIVE || bus.valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_rd: rd=%b state=%0d valid=%b want 0001/1/0", bus.fifo_rd, state, bus.valid_out);
    end
    @(negedge clk);
    checks++;
    if (bus.valid_out !== 1'b1 || bus.ch_out !== 2'd0 || bus.data_out !== mkw(0, 0)) begin
      errors++;
      $display("FAIL reset_first_word: valid=%b ch=%0d data=%h want 1/0/%h", bus.valid_out, bus.ch_out, bus.data_out, mkw(0, 0));
    end
    // Reset in the middle of the burst discards it
    reset_L = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.valid_out !== 1'b0 || bus.fifo_rd !== 4'b0000 || idle !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_burst: valid=%b rd=%b idle=%b want 0/0000/1", bus.valid_out, bus.fifo_rd, idle);
    end
  endtask

  task automatic test_round_robin();
    logic [8:0] e;
    logic [7:0] last;
    do_reset();
    for (int c = 0; c < N_CH; c++) load(c, 6);
    push_gap();
`ifdef VC_RD_STRICT_PRIO_EN
    push_group(0, 0, 6); push_gap();
    push_group(1, 0, 4); push_gap(); push_group(1, 4, 2); push_gap();
    push_group(2, 0, 4); push_gap(); push_group(2, 4, 2); push_gap();
    push_group(3, 0, 4); push_gap(); push_group(3, 4, 2); push_gap();
`else
    for (int c = 0; c < N_CH; c++) begin push_group(c, 0, 4); push_gap(); end
    for (int c = 0; c < N_CH; c++) begin push_group(c, 4, 2); push_gap(); end
`endif
    last = 8'h00;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      checks++;
      if (bus.valid_out !== e[8]) begin
        errors++;
        $display("FAIL rr_valid: got %b want %b", bus.valid_out, e[8]);
      end
      checks++;
      if (e[8]) begin
        if ({bus.ch_out, bus.data_out} !== e[7:0]) begin
          errors++;
          $display("FAIL rr_word: got ch=%0d data=%h want ch=%0d data=%h", bus.ch_out, bus.data_out, e[7:6], e[5:0]);
        end
        last = e[7:0];
      end else if ({bus.ch_out, bus.data_out} !== last) begin
        errors++;
        $display("FAIL rr_hold: got ch=%0d data=%h want ch=%0d data=%h", bus.ch_out, bus.data_out, last[7:6], last[5:0]);
      end
    end
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("FAIL rr_idle: got %b want 1", idle);
    end
  endtask

  task automatic test_single_channel();
    logic [8:0] e;
    logic [7:0] last;
    do_reset();
    load(2, 9);
    push_gap();
    push_group(2, 0, 4); push_gap();
    push_group(2, 4, 4); push_gap();
    push_group(2, 8, 1); push_gap();
    last = 8'h00;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      checks++;
      if (bus.valid_out !== e[8]) begin
        errors++;
        $display("FAIL single_valid: got %b want %b", bus.valid_out, e[8]);
      end
      checks++;
      if (e[8]) begin
        if ({bus.ch_out, bus.data_out} !== e[7:0]) begin
          errors++;
          $display("FAIL single_word: got ch=%0d data=%h want ch=%0d data=%h", bus.ch_out, bus.data_out, e[7:6], e[5:0]);
        end
        last = e[7:0];
      end else if ({bus.ch_out, bus.data_out} !== last) begin
        errors++;
        $display("FAIL single_hold: got ch=%0d data=%h want ch=%0d data=%h", bus.ch_out, bus.data_out, last[7:6], last[5:0]);
      end
    end
    checks++;
    if (idle !== 1'b1 || state !== ST_IDLE) begin
      errors++;
      $display("FAIL single_idle: idle=%b state=%0d want 1/0", idle, state);
    end
  endtask

  task automatic test_pause();
    logic [8:0] e;
    logic [7:0] last;
    do_reset();
    load(1, 6);
    load(2, 2);
    push_gap();
    push_group(1, 0, 2);
    last = 8'h00;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      checks++;
      if (bus.valid_out !== e[8] || (e[8] && {bus.ch_out, bus.data_out} !== e[7:0])) begin
        errors++;
        $display("FAIL pause_pre: got v=%b ch=%0d data=%h want v=%b ch=%0d data=%h",
                 bus.valid_out, bus.ch_out, bus.data_out, e[8], e[7:6], e[5:0]);
      end
      if (e[8]) last = e[7:0];
    end
    bus.pause = 1'b1;
    #1;
    checks++;
    if (bus.fifo_rd !== 4'b0000) begin
      errors++;
      $display("FAIL pause_rd_drop: got %b want 0000", bus.fifo_rd);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (state !== ST_PAUSE || bus.valid_out !== 1'b0 || bus.fifo_rd !== 4'b0000) begin
        errors++;
        $display("FAIL pause_hold: state=%0d valid=%b rd=%b want 2/0/0000", state, bus.valid_out, bus.fifo_rd);
      end
    end
    bus.pause = 1'b0;
    push_gap();
    push_group(1, 2, 2); push_gap();
`ifdef VC_RD_STRICT_PRIO_EN
    push_group(1, 4, 2); push_gap();
    push_group(2, 0, 2); push_gap();
`else
    push_group(2, 0, 2); push_gap();
    push_group(1, 4, 2); push_gap();
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      checks++;
      if (bus.valid_out !== e[8]) begin
        errors++;
        $display("FAIL pause_valid: got %b want %b", bus.valid_out, e[8]);
      end
      checks++;
      if (e[8]) begin
        if ({bus.ch_out, bus.data_out} !== e[7:0]) begin
          errors++;
          $display("FAIL pause_word: got ch=%0d data=%h want ch=%0d data=%h", bus.ch_out, bus.data_out, e[7:6], e[5:0]);
        end
        last = e[7:0];
      end else if ({bus.ch_out, bus.data_out} !== last) begin
        errors++;
        $display("FAIL pause_hold_out: got ch=%0d data=%h want ch=%0d data=%h", bus.ch_out, bus.data_out, last[7:6], last[5:0]);
      end
    end
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("FAIL pause_idle: got %b want 1", idle);
    end
  endtask

  task automatic test_empty_guard();
    logic [8:0] e;
    logic [7:0] last;
    do_reset();
    load(1, 1);
    load(3, 2);
    push_gap();
    push_group(1, 0, 1); push_gap();
    push_group(3, 0, 2); push_gap();
    last = 8'h00;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      checks++;
      if (bus.valid_out !== e[8]) begin
        errors++;
        $display("FAIL empty_valid: got %b want %b", bus.valid_out, e[8]);
      end
      checks++;
      if (e[8]) begin
        if ({bus.ch_out, bus.data_out} !== e[7:0]) begin
          errors++;
          $display("FAIL empty_word: got ch=%0d data=%h want ch=%0d data=%h", bus.ch_out, bus.data_out, e[7:6], e[5:0]);
        end
        last = e[7:0];
      end else if ({bus.ch_out, bus.data_out} !== last) begin
        errors++;
        $display("FAIL empty_hold: got ch=%0d data=%h want ch=%0d data=%h", bus.ch_out, bus.data_out, last[7:6], last[5:0]);
      end
    end
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("FAIL empty_idle: got %b want 1", idle);
    end
  endtask

`ifdef VC_RD_STRICT_PRIO_EN
  task automatic test_strict_prio();
    logic [8:0] e;
    logic [7:0] last;
    do_reset();
    load(3, 8);
    push_gap();
    push_group(3, 0, 2);
    last = 8'h00;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      checks++;
      if (bus.valid_out !== e[8] || (e[8] && {bus.ch_out, bus.data_out} !== e[7:0])) begin
        errors++;
        $display("FAIL prio_pre: got v=%b ch=%0d data=%h want v=%b ch=%0d data=%h",
                 bus.valid_out, bus.ch_out, bus.data_out, e[8], e[7:6], e[5:0]);
      end
      if (e[8]) last = e[7:0];
    end
    load(0, 3);
    #1;
    checks++;
    if (bus.fifo_rd !== 4'b0000) begin
      errors++;
      $display("FAIL prio_preempt_rd: got %b want 0000", bus.fifo_rd);
    end
    push_gap();
    push_group(0, 0, 3); push_gap();
    push_group(3, 2, 4); push_gap();
    push_group(3, 6, 2); push_gap();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      checks++;
      if (bus.valid_out !== e[8]) begin
        errors++;
        $display("FAIL prio_valid: got %b want %b", bus.valid_out, e[8]);
      end
      checks++;
      if (e[8]) begin
        if ({bus.ch_out, bus.data_out} !== e[7:0]) begin
          errors++;
          $display("FAIL prio_word: got ch=%0d data=%h want ch=%0d data=%h", bus.ch_out, bus.data_out, e[7:6], e[5:0]);
        end
        last = e[7:0];
      end else if ({bus.ch_out, bus.data_out} !== last) begin
        errors++;
        $display("FAIL prio_hold: got ch=%0d data=%h want ch=%0d data=%h", bus.ch_out, bus.data_out, last[7:6], last[5:0]);
      end
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    reset_L   = 1'b0;
    bus.pause = 1'b0;
    refresh();
    test_reset();
    test_round_robin();
    test_single_channel();
    test_pause();
    test_empty_guard();
`ifdef VC_RD_STRICT_PRIO_EN
    test_strict_prio();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
